// File: rtl/vga_spi_pkg.sv
// Shared constants and types for the VGA gain-control SPI link (driver and responder).
// Pure declarations: no logic, no latency.
// No flow control; both ends agree on framing through these constants.
package vga_spi_pkg;

  // Register map and framing
  localparam logic [7:0] VGA_GAIN_ADDR  = 8'h02;
  localparam logic [6:0] VGA_GAIN_RST   = 7'h20;
  localparam int         VGA_FRAME_BITS = 16;

  // The bit counter runs one past a full frame so that over-long frames remain distinguishable
  localparam int         VGA_CNT_W   = 5;
  localparam logic [4:0] VGA_CNT_FULL = 5'(VGA_FRAME_BITS);
  localparam logic [4:0] VGA_CNT_SAT  = 5'(VGA_FRAME_BITS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // One decoded write: address byte followed by data byte
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } frame_t;

  // A frame is well formed when exactly 16 bits arrived and both byte MSBs are clear
  function automatic logic frame_ok(input logic [15:0] sh, input logic [4:0] cnt);
    return (cnt == VGA_CNT_FULL) && !sh[15] && !sh[7];
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a history flop for edge pulses.
// Latency: level valid SYNC_STAGES clocks after the pin is sampled; rise/fall pulses are combinational on that level.
// No backpressure; pulses last exactly one clock.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_d};

  // Shift the pin through the synchroniser chain and remember the previous synchronised level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = sync_q[SYNC_STAGES-1];
  assign o_rise = o_lvl & ~hist_q;
  assign o_fall = ~o_lvl & hist_q;

endmodule

// File: rtl/vga_spi_rx.sv
// Write-only SPI responder: decodes 16-bit address/data frames and shadows the VGA gain register.
// Latency: commit pulse SYNC_STAGES+1 clocks after cs_n is first sampled high at frame end.
// No backpressure: every frame commits unconditionally as valid write or frame error.
module vga_spi_rx
  import vga_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 i_clk125,
  input  logic                 i_srst,
  input  logic                 i_cs_n,
  input  logic                 i_sclk,
  input  logic                 i_mosi,
  output logic                 o_busy,
  output logic                 o_wr_valid,
  output logic [7:0]           o_wr_addr,
  output logic [7:0]           o_wr_data,
  output logic [6:0]           o_gain_reg,
  output logic                 o_pwdn,
  output logic                 o_frame_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // Synchronised pin views
  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // FSM and decode strobes
  state_e state_q, state_d;
  logic   clr_en;
  logic   shift_en;
  logic   commit_wr;
  logic   commit_err;

  // Datapath registers
  logic [15:0]          shift_q, shift_d;
  logic [VGA_CNT_W-1:0] cnt_q, cnt_d;
  frame_t               wr_q, wr_d;
  logic [6:0]           gain_q, gain_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 frame_err_q, frame_err_d;

  // Only the sclk rise and the mosi level are consumed
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall};

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk  (i_clk125),
    .i_rst  (i_srst),
    .i_d    (i_cs_n),
    .o_lvl  (cs_lvl),
    .o_rise (cs_rise),
    .o_fall (cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk  (i_clk125),
    .i_rst  (i_srst),
    .i_d    (i_sclk),
    .o_lvl  (sclk_lvl),
    .o_rise (sclk_rise),
    .o_fall (sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk  (i_clk125),
    .i_rst  (i_srst),
    .i_d    (i_mosi),
    .o_lvl  (mosi_lvl),
    .o_rise (mosi_rise),
    .o_fall (mosi_fall)
  );

  // FSM state register; reset abandons any frame in flight
  always_ff @(posedge i_clk125 or posedge i_srst) begin
    if (i_srst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a frame spans the synchronised cs_n low window
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: frame start clears, sclk rises shift, cs_n rise commits.
  // An sclk rise coincident with either cs_n edge is dropped, since cs_n edges take priority.
  always_comb begin
    clr_en     = 1'b0;
    shift_en   = 1'b0;
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) clr_en = 1'b1;
      end
      SHIFT: begin
        if (cs_rise) begin
          if (cnt_q != '0) begin
            if (frame_ok(shift_q, cnt_q)) commit_wr  = 1'b1;
            else                          commit_err = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next state: shifter, saturating bit count, commit targets, saturating error count
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    gain_d    = gain_q;
    err_cnt_d = err_cnt_q;
    if (clr_en) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[14:0], mosi_lvl};
      if (cnt_q != VGA_CNT_SAT) cnt_d = cnt_q + 5'd1;
    end
    if (commit_wr) begin
      wr_d.addr = shift_q[15:8];
      wr_d.data = shift_q[7:0];
      if (shift_q[15:8] == VGA_GAIN_ADDR) gain_d = shift_q[6:0];
    end
    if (commit_err && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + ERR_ONE;
  end

  assign wr_valid_d  = commit_wr;
  assign frame_err_d = commit_err;

  // Datapath registers; the commit pulses and their payload update on the same edge
  always_ff @(posedge i_clk125 or posedge i_srst) begin
    if (i_srst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      gain_q      <= VGA_GAIN_RST;
      err_cnt_q   <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      gain_q      <= gain_d;
      err_cnt_q   <= err_cnt_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_busy      = ~cs_lvl;
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_addr   = wr_q.addr;
  assign o_wr_data   = wr_q.data;
  assign o_gain_reg  = gain_q;
  assign o_pwdn      = gain_q[6];
  assign o_frame_err = frame_err_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: doc/vga_spi_rx.md
# vga_spi_rx

SPI write-only responder for the ADC-board VGA gain control bus. It receives the 16-bit frames issued by the FPGA-side SPI driver: an 8-bit address (A7 first), then 8-bit data (D7 first). It decodes each frame and holds a shadow copy of the VGA gain-control register (address 0x02). It sits on the receiving end of the VGA SPI pins, for loopback verification of the driver and for on-board gain readback to software.

## Interface
Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each SPI input (minimum 2).
- ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
- i_clk125  in  1  system clock, 125 MHz.
- i_srst  in  1  reset, asynchronous, active-high.
- i_cs_n  in  1  SPI chip select, active-low, asynchronous to i_clk125.
- i_sclk  in  1  SPI clock, asynchronous; data is sampled on its rising edge.
- i_mosi  in  1  SPI data, asynchronous.
- o_busy  out  1  synchronised chip select is low (frame in progress).
- o_wr_valid  out  1  one-cycle pulse when a well-formed frame has been received.
- o_wr_addr  out  8  address of the last valid frame.
- o_wr_data  out  8  data of the last valid frame.
- o_gain_reg  out  7  shadow gain register. Bit 6 is power-down; bits 5:0 are attenuation code.
- o_pwdn  out  1  equal to o_gain_reg[6].
- o_frame_err  out  1  one-cycle pulse when a malformed frame is received.
- o_err_cnt  out  ERR_CNT_W  saturating count of malformed frames.

## Operation
- Input conditioning:
  - i_cs_n, i_sclk and i_mosi each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Synchroniser reset values: cs_n=1, sclk=0, mosi=0.
- States:
  - IDLE: synchronised cs_n is high.
  - SHIFT: synchronised cs_n is low.
- IDLE -> SHIFT on a detected cs_n falling edge. On entry, the 16-bit shift register and the 5-bit bit counter clear.
- In SHIFT, each detected sclk rising edge does two things:
  - shifts the synchronised mosi into the shift register LSB (MSB-first framing);
  - increments the bit counter, which saturates at 17.
- SHIFT -> IDLE on a detected cs_n rising edge, with this commit rule:
  - Count 0: no-op, no pulse of any kind.
  - Count 16, shift[15]=0 (A7) and shift[7]=0 (D7): the frame is valid. Pulse o_wr_valid and load o_wr_addr=shift[15:8] and o_wr_data=shift[7:0]. If the address is 0x02, also load o_gain_reg=shift[6:0].
  - Any other count (1–15, or 17 meaning more than 16 bits), or A7=1, or D7=1: the frame is malformed. Pulse o_frame_err and increment o_err_cnt, saturating at all-ones. o_wr_addr, o_wr_data and o_gain_reg are unchanged.
- A valid frame to any address other than 0x02 still pulses o_wr_valid with its address and data; the gain register is untouched.
- sclk edges while in IDLE are ignored.
- Simultaneous events:
  - If an sclk rising edge is detected in the same cycle as a cs_n rising edge, the sclk edge is ignored; the commit uses the prior count.
  - If an sclk rising edge is detected in the same cycle as a cs_n falling edge, the sclk edge is ignored; no bit is captured.
- o_wr_valid and o_frame_err are mutually exclusive.

## Timing
- Reset values: o_busy=0, o_wr_valid=0, o_wr_addr=0x00, o_wr_data=0x00, o_gain_reg=0x20, o_pwdn=0, o_frame_err=0, o_err_cnt=0.
- Reset asserted mid-frame aborts the frame immediately and returns to IDLE. No pulse is produced.
- Commit latency: o_wr_valid / o_frame_err is high for exactly one cycle, starting SYNC_STAGES+1 rising edges of i_clk125 after the first edge that samples i_cs_n high.
  - o_wr_addr, o_wr_data, o_gain_reg and o_pwdn update on the same edge that raises o_wr_valid.
  - o_err_cnt updates on the same edge that raises o_frame_err.
- o_busy follows the synchronised cs_n: it asserts SYNC_STAGES edges after i_cs_n is sampled low.
- Input constraints:
  - sclk high and low phases each ≥ SYNC_STAGES+2 clk125 cycles.
  - mosi stable for ≥ SYNC_STAGES+1 cycles around each sclk rise.
  - cs_n high gap ≥ 2 cycles between frames.
  - The driver's 16-cycle half-period satisfies all of these.
- No back-pressure: frames commit unconditionally.

## Structure
- Shared package vga_spi_pkg:
  - VGA_GAIN_ADDR = 8'h02
  - VGA_GAIN_RST = 7'h20
  - VGA_FRAME_BITS = 16
  - state enum {IDLE, SHIFT}
  - The driver uses the same constants.
- One sub-module, spi_in_sync: a parameterised SYNC_STAGES synchroniser with a history flop, instantiated once per SPI input. It exposes the synchronised level plus rise/fall pulses.
- The top level holds the FSM, shift register, bit counter, commit logic, shadow register and error counter.

## Test plan
- Gain write: frame 0x020A (A7..D0) with a 16-cycle half-period sclk. Required: one o_wr_valid pulse with addr=0x02, data=0x0A; o_gain_reg=0x0A; o_pwdn=0; latency exactly SYNC_STAGES+1 after the cs_n rise.
- Power-down write: frame 0x0245. Required: o_gain_reg=0x45, o_pwdn=1. Then frame 0x0533. Required: o_wr_valid with addr=0x05, data=0x33; o_gain_reg stays 0x45.
- Malformed frames, each producing one o_frame_err pulse, no o_wr_valid and o_gain_reg unchanged; o_err_cnt=3 after all three:
  - a 15-bit frame;
  - a 17-bit frame;
  - frame 0x8210 (A7=1).
- Empty frame: a cs_n low/high pulse with no sclk edges. Required: no pulse, o_err_cnt unchanged.
- Reset mid-frame: assert i_srst after 8 bits of 0x0211. Required: all outputs return to reset values (o_gain_reg=0x20). The next complete frame 0x0207 is accepted and gives o_gain_reg=0x07.
- Stress: 300 back-to-back short frames with a 2-cycle cs_n gap. Required: o_err_cnt saturates at 255 and never wraps. Also drive sclk and cs_n edges coincident. Required: the sclk edge is ignored at both frame start and frame end.
